csr_bank: RTL

//  Parametrised control/status register bank behind the AXI-Lite slave. Adds byte strobes and a

---
 rtl/csr_bank.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/csr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : csr_bank
//  Description : Parametrised control/status register bank for the video
//                pipeline. Byte-strobed writes, registered read port,
//                double-buffered RES_X/RES_Y committed on frame boundaries,
//                W1C interrupt status with mask, read-only frame counter and
//                decode-error flags.
//  Ports       : clk, resetn            - clock, synchronous active-low reset
//                write_en/addr/data/strb - write port (one write per cycle)
//                write_err              - pulse: write to unimplemented index
//                read_en/addr           - read request
//                read_data/valid/err    - registered read result (1 cycle)
//                frame_start            - frame boundary pulse
//                event_in               - per-source interrupt event pulses
//                irq                    - registered OR of status & mask
//                res_x, res_y           - active (committed) resolution
//                ctrl_enable            - CTRL[0]
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_bank #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int NUM_IRQ    = 8,
    parameter int RES_X_RST  = 640,
    parameter int RES_Y_RST  = 480
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_err,
    input  logic                    read_en,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    read_err,
    input  logic                    frame_start,
    input  logic [NUM_IRQ-1:0]      event_in,
    output logic                    irq,
    output logic [DATA_WIDTH-1:0]   res_x,
    output logic [DATA_WIDTH-1:0]   res_y,
    output logic                    ctrl_enable
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int NUM_SLOTS = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] c_addr_res_x      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_addr_res_y      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl       = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_addr_irq_status = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_addr_irq_mask   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_addr_frame_cnt  = ADDR_WIDTH'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_shadow_x;
    logic [DATA_WIDTH-1:0] r_shadow_y;
    logic [DATA_WIDTH-1:0] r_res_x;
    logic [DATA_WIDTH-1:0] r_res_y;
    logic [DATA_WIDTH-1:0] r_ctrl;
    logic [NUM_IRQ-1:0]    r_irq_status;
    logic [NUM_IRQ-1:0]    r_irq_mask;
    logic [DATA_WIDTH-1:0] r_frame_cnt;
    // Indexed directly by the address so the read mux needs no offset
    // arithmetic; only slots 6..NUM_REGS-1 are ever written or read.
    logic [DATA_WIDTH-1:0] r_scratch [0:NUM_SLOTS-1];
    logic                  r_irq;
    logic                  r_write_err;
    logic                  r_read_valid;
    logic                  r_read_err;
    logic [DATA_WIDTH-1:0] r_read_data;

    logic [DATA_WIDTH-1:0] w_bytemask;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_hit;
    logic [NUM_IRQ-1:0]    w_w1c;
    logic [NUM_IRQ-1:0]    w_status_next;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
        assign w_bytemask[b*8 +: 8] = {8{write_strb[b]}};
    end

    assign w_wr_in_range = (32'(write_addr) < NUM_REGS);
    assign w_rd_in_range = (32'(read_addr)  < NUM_REGS);
    assign w_wr_hit      = write_en && w_wr_in_range;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // A new event on a bit overrides a simultaneous W1C of that bit.
    assign w_w1c = (w_wr_hit && (write_addr == c_addr_irq_status))
                 ? (write_data[NUM_IRQ-1:0] & w_bytemask[NUM_IRQ-1:0])
                 : '0;
    assign w_status_next = (r_irq_status & ~w_w1c) | event_in;

    // ------------------------------------------------------------------
    // Register file and pipeline-facing state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shadow_x   <= DATA_WIDTH'(RES_X_RST);
            r_shadow_y   <= DATA_WIDTH'(RES_Y_RST);
            r_res_x      <= DATA_WIDTH'(RES_X_RST);
            r_res_y      <= DATA_WIDTH'(RES_Y_RST);
            r_ctrl       <= '0;
            r_irq_status <= '0;
            r_irq_mask   <= '0;
            r_frame_cnt  <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                case (write_addr)
                    c_addr_res_x: r_shadow_x <= f_merge(r_shadow_x, write_data, w_bytemask);
                    c_addr_res_y: r_shadow_y <= f_merge(r_shadow_y, write_data, w_bytemask);
                    c_addr_ctrl:  r_ctrl     <= f_merge(r_ctrl, write_data, w_bytemask);
                    c_addr_irq_mask: r_irq_mask <=
                        (r_irq_mask & ~w_bytemask[NUM_IRQ-1:0]) |
                        (write_data[NUM_IRQ-1:0] & w_bytemask[NUM_IRQ-1:0]);
                    default: ;
                endcase
            end

            r_irq_status <= w_status_next;

            if (frame_start && r_ctrl[0]) begin
                r_frame_cnt <= r_frame_cnt + DATA_WIDTH'(1);
            end

            // Commit samples the pre-write shadow, so a shadow write landing
            // on a frame_start cycle is deferred to the following frame.
            if (!r_ctrl[0] || frame_start) begin
                r_res_x <= r_shadow_x;
                r_res_y <= r_shadow_y;
            end

            r_irq <= |(r_irq_status & r_irq_mask);
        end
    end

    for (genvar g = 6; g < NUM_REGS; g++) begin : g_scratch
        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_scratch[g] <= '0;
            end else if (w_wr_hit && (write_addr == ADDR_WIDTH'(g))) begin
                r_scratch[g] <= f_merge(r_scratch[g], write_data, w_bytemask);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        if (w_rd_in_range) begin
            case (read_addr)
                c_addr_res_x:      w_rd_mux = r_shadow_x;
                c_addr_res_y:      w_rd_mux = r_shadow_y;
                c_addr_ctrl:       w_rd_mux = r_ctrl;
                c_addr_irq_status: w_rd_mux = DATA_WIDTH'(r_irq_status);
                c_addr_irq_mask:   w_rd_mux = DATA_WIDTH'(r_irq_mask);
                c_addr_frame_cnt:  w_rd_mux = r_frame_cnt;
                default:           w_rd_mux = r_scratch[read_addr];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_read_err   <= 1'b0;
            r_write_err  <= 1'b0;
        end else begin
            r_read_valid <= read_en;
            r_read_err   <= read_en && !w_rd_in_range;
            r_write_err  <= write_en && !w_wr_in_range;
            if (read_en) begin
                r_read_data <= w_rd_mux;
            end
        end
    end

    assign write_err   = r_write_err;
    assign read_data   = r_read_data;
    assign read_valid  = r_read_valid;
    assign read_err    = r_read_err;
    assign irq         = r_irq;
    assign res_x       = r_res_x;
    assign res_y       = r_res_y;
    assign ctrl_enable = r_ctrl[0];

endmodule
`default_nettype wire
